load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the byte-addressed, little-endian data-memory port. Sits between the CPU
//  execute stage and data memory. Accepts one load/store at a time over a valid/ready handshake
//  and drives the memory's address/data/width/write signals. Sign- or zero-extends load data.
//  Splits misaligned halfword/word accesses into sequential byte accesses.
// PARAMETERS
//  ADDR_W           32  address width; byte address arithmetic wraps modulo 2^ADDR_W
//  SPLIT_MISALIGNED 1   1: split misaligned accesses into bytes; 0: reject them with resp_error
// PORTS
//  clk         in   1       system clock; all state changes on posedge
//  rst_n       in   1       synchronous reset, active-low
//  req_valid   in   1       CPU request valid
//  req_ready   out  1       unit can accept a request (high only in IDLE)
//  req_write   in   1       1 = store, 0 = load
//  req_funct3  in   3       RV32I funct3: LB/SB=000 LH/SH=001 LW/SW=010 LBU=100 LHU=101
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data (bytes taken from LSB upward)
//  resp_valid  out  1       one-cycle pulse: access complete
//  resp_rdata  out  32      extended load data (0 for stores and errors)
//  resp_error  out  1       qualified by resp_valid: illegal funct3 or rejected misalignment
//  mem_addr    out  ADDR_W  memory byte address
//  mem_wdata   out  32      memory write data, little-endian lanes
//  mem_width   out  2       00 byte, 01 half, 10 word
//  mem_write   out  1       memory write enable, sampled by memory on posedge clk
//  mem_rdata   in   32      combinational read data {m[a+3],m[a+2],m[a+1],m[a]}
// BEHAVIOUR
//  Reset (rst_n low at a posedge): state=IDLE, byte counter=0, all outputs 0.
//   - req_ready = (state==IDLE) & rst_n; mem_write is gated by rst_n combinationally.
//  States: IDLE, ACCESS, SPLIT, RESP.
//  - IDLE: on req_valid&req_ready, latch addr/wdata/funct3/write.
//    - Illegal (funct3 011/110/111, or 100/101 with write=1) -> RESP with error.
//    - Aligned (byte; half with addr[0]=0; word with addr[1:0]=0) -> ACCESS.
//    - Misaligned -> SPLIT if SPLIT_MISALIGNED, else RESP with error.
//  - ACCESS (1 cycle): mem_addr=addr, mem_width=funct3[1:0], mem_wdata=wdata, mem_write=write.
//    Capture mem_rdata at the edge -> RESP.
//  - SPLIT: N=2 (half) or 4 (word) cycles, cnt 0..N-1.
//    - Each cycle: mem_addr=addr+cnt (wrapping), mem_width=00, mem_wdata[7:0]=wdata byte cnt,
//      mem_write=write.
//    - Capture mem_rdata[7:0] into load byte lane cnt.
//    - Go to RESP after cnt=N-1.
//  - RESP (1 cycle): resp_valid=1 -> IDLE. No response backpressure.
//  Latency from accept edge: resp_valid is high in cycle 2 (aligned), N+1 (split), 1 (error).
//  Idle memory outputs: outside ACCESS/SPLIT, mem_write=0, mem_width=00, mem_addr=0, mem_wdata=0.
//  Load extension:
//   - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW is the full 32 bits.
//  Errors: no memory cycle is issued, resp_rdata=0.
//  Stores: resp_rdata=0, resp_error=0.
//  Reset mid-operation: the access is abandoned and no response is produced.
//   - Bytes already written before the reset cycle remain written; none are written in or after it.
//  Requests arriving while req_ready=0 are ignored; the CPU must hold them.
// TESTING
//  1 mem[0x10..0x13]=78,56,34,12; LW 0x10 -> one cycle mem_width=10; resp cycle 2, rdata=0x12345678
//  2 mem[0x13]=0x80; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 (0x8034) -> 0xFFFF8034
//  3 SW 0x21 data 0xAABBCCDD -> byte writes 21=DD 22=CC 23=BB 24=AA in cycles 1-4; resp cycle 5
//  4 LH 0xFFFFFFFF, mem[0xFFFFFFFF]=0x34, mem[0]=0x92 -> mem_addr FFFFFFFF then 0; rdata 0xFFFF9234
//  5 funct3=011 load; SW misaligned with SPLIT_MISALIGNED=0 -> resp cycle 1, error=1, no mem_write
//  6 SW 0x41 misaligned, rst_n low in cycle 3 -> only 0x41,0x42 written; no resp; IDLE after release

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request/response and data-memory port bundle for the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        mem_width;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr, mem_wdata, mem_width, mem_write
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr, mem_wdata, mem_width, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator with byte splitting of misaligned accesses
module load_store_unit #(
  parameter int ADDR_W           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.master   bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [2:0]        r_funct3;
  logic              r_write;
  logic              r_error;
  logic [1:0]        r_cnt;

  logic              w_accept;
  logic              w_illegal;
  logic              w_misaligned;
  logic [1:0]        w_last_cnt;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_ext;
  logic              w_mem_write;

  assign w_accept     = bus.req_valid & bus.req_ready;
  assign w_illegal    = (bus.req_funct3 == 3'b011) | (bus.req_funct3[2:1] == 2'b11) |
                        (bus.req_funct3[2] & bus.req_write);
  assign w_misaligned = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                        ((bus.req_funct3[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00));
  assign w_last_cnt   = (r_funct3[1:0] == 2'b10) ? 2'd3 : 2'd1;
  assign w_wbyte      = r_wdata[8*r_cnt +: 8];

  // Stores and errors report zero data; loads extend according to funct3.
  always_comb begin
    w_ext = 32'd0;
    if (!r_error && !r_write) begin
      case (r_funct3)
        3'b000:  w_ext = {{24{r_rdata[7]}}, r_rdata[7:0]};
        3'b001:  w_ext = {{16{r_rdata[15]}}, r_rdata[15:0]};
        3'b100:  w_ext = {24'd0, r_rdata[7:0]};
        3'b101:  w_ext = {16'd0, r_rdata[15:0]};
        default: w_ext = r_rdata;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    w_mem_write    = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_error = 1'b0;
    bus.resp_rdata = 32'd0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = 32'd0;
    bus.mem_width  = 2'b00;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = rst_n;
        if (w_accept) begin
          if (w_illegal)         w_next = S_RESP;
          else if (!w_misaligned) w_next = S_ACCESS;
          else if (SPLIT_MISALIGNED) w_next = S_SPLIT;
          else                   w_next = S_RESP;
        end
      end
      S_ACCESS: begin
        bus.mem_addr  = r_addr;
        bus.mem_width = r_funct3[1:0];
        bus.mem_wdata = r_wdata;
        w_mem_write   = r_write;
        w_next        = S_RESP;
      end
      S_SPLIT: begin
        bus.mem_addr  = r_addr + ADDR_W'(r_cnt);
        bus.mem_wdata = {24'd0, w_wbyte};
        w_mem_write   = r_write;
        if (r_cnt == w_last_cnt) w_next = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = rst_n;
        bus.resp_error = r_error;
        bus.resp_rdata = w_ext;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // A reset cycle must never commit a write, even mid-split.
    bus.mem_write = w_mem_write & rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_funct3 <= 3'd0;
      r_write  <= 1'b0;
      r_error  <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_funct3 <= bus.req_funct3;
            r_write  <= bus.req_write;
            r_error  <= w_illegal | (w_misaligned & !SPLIT_MISALIGNED);
            r_rdata  <= 32'd0;
            r_cnt    <= 2'd0;
          end
        end
        S_ACCESS: r_rdata <= bus.mem_rdata;
        S_SPLIT: begin
          r_rdata[8*r_cnt +: 8] <= bus.mem_rdata[7:0];
          r_cnt                 <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - cycle-exact checks of load_store_unit against a transaction-level model
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) ifc ();
  load_store_unit_if #(.ADDR_W(32)) ifc_ns ();

  load_store_unit #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  load_store_unit #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (.clk(clk), .rst_n(rst_n), .bus(ifc_ns));

  // Byte memory aliased modulo 256; only the initial block writes it, stores are checked on the bus.
  logic [7:0] mem [256];
  logic [7:0] ra, ra_ns;
  assign ra    = ifc.mem_addr[7:0];
  assign ra_ns = ifc_ns.mem_addr[7:0];
  assign ifc.mem_rdata    = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
  assign ifc_ns.mem_rdata = {mem[ra_ns + 8'd3], mem[ra_ns + 8'd2], mem[ra_ns + 8'd1], mem[ra_ns]};

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  assign ifc.req_valid     = req_valid & !sel;
  assign ifc_ns.req_valid  = req_valid & sel;
  assign ifc.req_write     = req_write;
  assign ifc_ns.req_write  = req_write;
  assign ifc.req_funct3    = req_funct3;
  assign ifc_ns.req_funct3 = req_funct3;
  assign ifc.req_addr      = req_addr;
  assign ifc_ns.req_addr   = req_addr;
  assign ifc.req_wdata     = req_wdata;
  assign ifc_ns.req_wdata  = req_wdata;

  int errors = 0;
  int checks = 0;
  logic [101:0] exp_q [$];

  function automatic logic [101:0] pk(logic [31:0] a, logic [1:0] wd, logic [31:0] d, logic w,
                                      logic rv, logic er, logic [31:0] rd, logic rdy);
    return {a, wd, d, w, rv, er, rd, rdy};
  endfunction

  function automatic logic [101:0] observe();
    if (sel)
      return pk(ifc_ns.mem_addr, ifc_ns.mem_width, ifc_ns.mem_wdata, ifc_ns.mem_write,
                ifc_ns.resp_valid, ifc_ns.resp_error, ifc_ns.resp_rdata, ifc_ns.req_ready);
    return pk(ifc.mem_addr, ifc.mem_width, ifc.mem_wdata, ifc.mem_write,
              ifc.resp_valid, ifc.resp_error, ifc.resp_rdata, ifc.req_ready);
  endfunction

  // Expected per-cycle bus activity after the accept edge, derived from the access rules.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit split);
    int size;
    bit illegal, misal;
    logic [31:0] v, r;
    exp_q.delete();
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (f3 >= 3'd4 && w);
    misal   = (size == 2 && a % 2 != 0) || (size == 4 && a % 4 != 0);
    if (illegal || (misal && !split)) begin
      exp_q.push_back(pk(0, 0, 0, 0, 1, 1, 0, 0));
      return;
    end
    v = 0;
    for (int i = 0; i < size; i++) v = v | (32'(mem[8'(a + 32'(i))]) << (8 * i));
    if (w)              r = 0;
    else if (size == 1) r = f3[2] ? v : {{24{v[7]}}, v[7:0]};
    else if (size == 2) r = f3[2] ? v : {{16{v[15]}}, v[15:0]};
    else                r = v;
    if (!misal)
      exp_q.push_back(pk(a, (size == 1) ? 2'd0 : (size == 2) ? 2'd1 : 2'd2, d, w, 0, 0, 0, 0));
    else
      for (int i = 0; i < size; i++)
        exp_q.push_back(pk(a + 32'(i), 2'd0, (d >> (8 * i)) & 32'hFF, w, 0, 0, 0, 0));
    exp_q.push_back(pk(0, 0, 0, 0, 1, 0, r, 0));
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input string name);
    logic [101:0] obs;
    model(w, f3, a, d, !sel);
    @(negedge clk);
    checks++;
    if ((sel ? ifc_ns.req_ready : ifc.req_ready) !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got 0 expected 1", name);
    end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    // Busy-period requests must be ignored.
    req_valid = 1'(($urandom) & 1); req_write = 1'(($urandom) & 1);
    req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs = observe();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, obs, exp_q[i]);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifc.req_ready, ifc.resp_valid, ifc.resp_error, ifc.resp_rdata, ifc.mem_addr,
         ifc.mem_wdata, ifc.mem_width, ifc.mem_write} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero expected all zero");
    end
    checks++;
    if ({ifc_ns.req_ready, ifc_ns.resp_valid, ifc_ns.mem_write} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs_ns: got nonzero expected zero");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_load();
    mem[8'h10] = 8'h78; mem[8'h11] = 8'h56; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;
    do_req(0, 3'b010, 32'h10, 32'h0, "lw_0x10");
    checks++;
    if (exp_q[1] !== pk(0, 0, 0, 0, 1, 0, 32'h12345678, 0)) begin
      errors++;
      $display("FAIL lw_model: got %h expected 12345678", exp_q[1][32:1]);
    end
  endtask

  task automatic test_extension();
    mem[8'h13] = 8'h80;
    do_req(0, 3'b000, 32'h13, 32'h0, "lb_0x13");
    do_req(0, 3'b100, 32'h13, 32'h0, "lbu_0x13");
    do_req(0, 3'b001, 32'h12, 32'h0, "lh_0x12");
    do_req(0, 3'b101, 32'h12, 32'h0, "lhu_0x12");
  endtask

  task automatic test_split_store();
    do_req(1, 3'b010, 32'h21, 32'hAABBCCDD, "sw_0x21_split");
    do_req(1, 3'b001, 32'h33, 32'h00001234, "sh_0x33_split");
  endtask

  task automatic test_wrap();
    mem[8'hFF] = 8'h34; mem[8'h00] = 8'h92;
    do_req(0, 3'b001, 32'hFFFFFFFF, 32'h0, "lh_wrap");
    do_req(0, 3'b010, 32'hFFFFFFFE, 32'h0, "lw_wrap");
  endtask

  task automatic test_errors();
    do_req(0, 3'b011, 32'h10, 32'h0, "funct3_011");
    do_req(1, 3'b100, 32'h10, 32'h5, "store_lbu");
    do_req(0, 3'b111, 32'h10, 32'h0, "funct3_111");
  endtask

  task automatic test_no_split();
    sel = 1'b1;
    do_req(1, 3'b010, 32'h41, 32'hDEADBEEF, "ns_sw_misaligned");
    do_req(0, 3'b001, 32'h43, 32'h0, "ns_lh_misaligned");
    do_req(0, 3'b010, 32'h10, 32'h0, "ns_lw_aligned");
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [101:0] obs;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h41; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = observe();
      checks++;
      if (obs !== pk(32'h41 + 32'(i), 0, (32'h11223344 >> (8 * i)) & 32'hFF, 1, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL rst_mid cycle %0d: got %h", i + 1, obs);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.mem_write, ifc.resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_cycle3: got write=%b resp=%b expected 0 0", ifc.mem_write, ifc.resp_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      obs = observe();
      checks++;
      if (obs !== pk(0, 0, 0, 0, 0, 0, 0, 1)) begin
        errors++;
        $display("FAIL rst_mid_after %0d: got %h expected idle", i, obs);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++)
      do_req(1'($urandom & 1), 3'($urandom), $urandom, $urandom, "random");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_aligned_load();
    test_extension();
    test_split_store();
    test_wrap();
    test_errors();
    test_no_split();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
